dice_roller: RTL and testbench



---
 rtl/dice_roller.sv | 149 ++++++++++++++
 tb/tb_dice_roller.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dice_roller.sv
// dice_roller: debounced roll button, free-running 8-bit LFSR and timed roll
// animation producing a 3-bit face value (0 = blank, 1-6 = face).
// Optional feature macro DICE_ANIM_EN: when defined, every intermediate face is
// shown during a roll; when undefined, val stays blank until the final face lands.
module dice_roller #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned ROLL_TICK       = 5000000,
    parameter int unsigned ROLL_STEPS      = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn,
    output logic [2:0] val,
    output logic       rolling,
    output logic       done
);

    localparam int unsigned DbW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned TickW = $clog2(ROLL_TICK + 1);
    localparam int unsigned StepW = $clog2(ROLL_STEPS + 1);

    typedef enum logic [1:0] {StIdle, StRoll, StShow} state_e;

    logic             sync1_q, sync2_q;
    logic [DbW-1:0]   db_cnt_q;
    logic             db_lvl_q;
    logic             press_q;
    logic [7:0]       lfsr_q, lfsr_d;
    logic [2:0]       cand;
    logic [2:0]       next_face;
    state_e           state_q;
    logic [TickW-1:0] tick_q;
    logic [StepW-1:0] step_q;
    logic [2:0]       face_q;
    logic [2:0]       val_q;
    logic             rolling_q;
    logic             done_q;

    // Two-flop synchronizer for the asynchronous button
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
        end
    end

    // Debouncer: accept a new level after DEBOUNCE_CYCLES consecutive differing
    // samples; press_q pulses for one cycle on an accepted 0->1 change
    always_ff @(posedge clk) begin
        if (rst) begin
            db_cnt_q <= '0;
            db_lvl_q <= 1'b0;
            press_q  <= 1'b0;
        end else begin
            press_q <= 1'b0;
            if (sync2_q != db_lvl_q) begin
                if (db_cnt_q == DbW'(DEBOUNCE_CYCLES - 1)) begin
                    db_lvl_q <= sync2_q;
                    db_cnt_q <= '0;
                    press_q  <= sync2_q;
                end else begin
                    db_cnt_q <= db_cnt_q + 1'b1;
                end
            end else begin
                db_cnt_q <= '0;
            end
        end
    end

    // LFSR next state and candidate face (x^8+x^6+x^5+x^4+1, shift left)
    always_comb begin
        lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        cand   = 3'(lfsr_q % 8'd6) + 3'd1;
        // Bump a repeated face so every step visibly changes
        if (cand == face_q) begin
            next_face = (cand == 3'd6) ? 3'd1 : cand + 3'd1;
        end else begin
            next_face = cand;
        end
    end

    // LFSR runs every cycle so press timing picks the result
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= 8'hA5;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    // Roll FSM with tick/step counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            tick_q    <= '0;
            step_q    <= '0;
            face_q    <= 3'd0;
            val_q     <= 3'd0;
            rolling_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle, StShow: begin
                    if (press_q) begin
                        state_q   <= StRoll;
                        tick_q    <= '0;
                        step_q    <= '0;
                        rolling_q <= 1'b1;
`ifndef DICE_ANIM_EN
                        val_q     <= 3'd0;
`endif
                    end
                end
                StRoll: begin
                    if (tick_q == TickW'(ROLL_TICK - 1)) begin
                        tick_q <= '0;
                        step_q <= step_q + 1'b1;
                        // face_q tracks the animation in both builds so the
                        // repeat-bump, and thus the final face, never differs
                        face_q <= next_face;
`ifdef DICE_ANIM_EN
                        val_q  <= next_face;
`endif
                        if (step_q == StepW'(ROLL_STEPS - 1)) begin
                            state_q   <= StShow;
                            rolling_q <= 1'b0;
                            done_q    <= 1'b1;
                            val_q     <= next_face;
                        end
                    end else begin
                        tick_q <= tick_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign val     = val_q;
    assign rolling = rolling_q;
    assign done    = done_q;

endmodule

// File: tb/tb_dice_roller.sv
// Bench for dice_roller with DEBOUNCE_CYCLES=4, ROLL_TICK=3, ROLL_STEPS=5.
// Honours DICE_ANIM_EN the same way as the design build.
module tb_dice_roller;

    localparam int Deb   = 4;
    localparam int Tick  = 3;
    localparam int Steps = 5;
`ifdef DICE_ANIM_EN
    localparam bit Anim = 1'b1;
`else
    localparam bit Anim = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn = 1'b0;
    logic [2:0] val;
    logic       rolling;
    logic       done;

    dice_roller #(
        .DEBOUNCE_CYCLES(Deb),
        .ROLL_TICK      (Tick),
        .ROLL_STEPS     (Steps)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .btn    (btn),
        .val    (val),
        .rolling(rolling),
        .done   (done)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: button sample history, debounced level as a window
    // condition, roll progress as elapsed cycles since roll start.
    bit         hist[0:Deb+1];
    bit         m_lvl;
    bit         m_press;
    int         m_phase;   // 0 idle, 1 rolling, 2 showing
    int         m_el;
    int         m_face;
    logic [7:0] m_lfsr;
    bit         m_valid = 1'b0;
    int         e_val;
    bit         e_roll;
    bit         e_done;

    always @(posedge clk) begin
        bit all_diff;
        int c;
        if (rst) begin
            for (int k = 0; k <= Deb + 1; k++) hist[k] = 1'b0;
            m_lvl   = 1'b0;
            m_press = 1'b0;
            m_phase = 0;
            m_el    = 0;
            m_face  = 0;
            m_lfsr  = 8'hA5;
            e_done  = 1'b0;
            m_valid = 1'b1;
        end else begin
            e_done = 1'b0;
            if (m_phase == 1) begin
                m_el++;
                if (m_el % Tick == 0) begin
                    c = int'(m_lfsr) % 6 + 1;
                    if (c == m_face) c = (c == 6) ? 1 : c + 1;
                    m_face = c;
                    if (m_el == Steps * Tick) begin
                        m_phase = 2;
                        e_done  = 1'b1;
                    end
                end
            end else if (m_press) begin
                m_phase = 1;
                m_el    = 0;
            end
            // hist[1..Deb] are the synchronized samples seen at the last Deb edges
            all_diff = 1'b1;
            for (int k = 1; k <= Deb; k++) if (hist[k] == m_lvl) all_diff = 1'b0;
            m_press = 1'b0;
            if (all_diff) begin
                m_lvl   = !m_lvl;
                m_press = m_lvl;
            end
            for (int k = Deb + 1; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = btn;
            m_lfsr  = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
        end
        e_roll = (m_phase == 1);
        e_val  = (Anim || m_phase != 1) ? m_face : 0;
    end

    // Cycle-by-cycle comparison against the model plus roll bookkeeping
    int cur_len = 0;
    int last_len = 0;
    int n_rolls = 0;
    int n_dones = 0;

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_val", int'(val), e_val);
            chk("model_rolling", int'(rolling), int'(e_roll));
            chk("model_done", int'(done), int'(e_done));
            if (val == 3'd7) chk("val_never_7", int'(val), 0);
        end
        if (rolling === 1'b1) begin
            cur_len++;
        end else if (cur_len != 0) begin
            last_len = cur_len;
            n_rolls++;
            cur_len = 0;
        end
        if (done === 1'b1) n_dones++;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    typedef struct {
        bit rst;
        bit btn;
        int cyc;
        bit e_roll;
        int e_dones;
        bit e_nz;
    } vec_t;

    vec_t tbl[8];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, r0;

        tbl[0] = '{1'b1, 1'b0, 2,   1'b0, 0, 1'b0};  // reset
        tbl[1] = '{1'b0, 1'b0, 50,  1'b0, 0, 1'b0};  // idle, no press
        tbl[2] = '{1'b0, 1'b1, 6,   1'b0, 0, 1'b0};  // debounce still pending
        tbl[3] = '{1'b0, 1'b1, 1,   1'b1, 0, 1'b0};  // rolling rises 7 cycles after btn
        tbl[4] = '{1'b0, 1'b1, 3,   1'b1, 0, Anim};  // first step after ROLL_TICK
        tbl[5] = '{1'b0, 1'b0, 11,  1'b1, 0, Anim};  // still rolling at cycle 14
        tbl[6] = '{1'b0, 1'b0, 1,   1'b0, 1, 1'b1};  // done on cycle 15
        tbl[7] = '{1'b0, 1'b0, 100, 1'b0, 0, 1'b1};  // result held

        for (int i = 0; i < 8; i++) begin
            d0  = n_dones;
            rst = tbl[i].rst;
            btn = tbl[i].btn;
            step(tbl[i].cyc);
            chk($sformatf("vec%0d_rolling", i), int'(rolling), int'(tbl[i].e_roll));
            chk($sformatf("vec%0d_dones", i), n_dones - d0, tbl[i].e_dones);
            chk($sformatf("vec%0d_val_nz", i), int'(val != 3'd0), int'(tbl[i].e_nz));
        end
        chk("first_roll_len", last_len, Steps * Tick);
        chk("final_in_range", int'(val >= 3'd1 && val <= 3'd6), 1);

        // Bouncing button from reset never produces a press
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        r0  = n_rolls;
        d0  = n_dones;
        for (int i = 0; i < 15; i++) begin
            btn = (i % 2 == 0);
            step(2);
        end
        btn = 1'b0;
        step(20);
        chk("bounce_rolls", n_rolls - r0 + int'(rolling), 0);
        chk("bounce_dones", n_dones - d0, 0);
        chk("bounce_val", int'(val), 0);

        // Second press while rolling is ignored
        r0 = n_rolls;
        d0 = n_dones;
        btn = 1'b1; step(4);
        btn = 1'b0; step(6);
        chk("ignored_rolling_mid", int'(rolling), 1);
        btn = 1'b1; step(4);
        btn = 1'b0; step(30);
        chk("ignored_rolls", n_rolls - r0, 1);
        chk("ignored_len", last_len, Steps * Tick);
        chk("ignored_dones", n_dones - d0, 1);

        // Press after done starts a fresh roll
        r0 = n_rolls;
        d0 = n_dones;
        btn = 1'b1; step(4);
        btn = 1'b0; step(30);
        chk("reroll_rolls", n_rolls - r0, 1);
        chk("reroll_len", last_len, Steps * Tick);
        chk("reroll_dones", n_dones - d0, 1);

        // Reset just after step 3 of a roll
        d0 = n_dones;
        btn = 1'b1; step(4);
        btn = 1'b0; step(3);
        chk("mid_rolling_start", int'(rolling), 1);
        step(3 * Tick);
        rst = 1'b1; step(1);
        rst = 1'b0;
        chk("mid_rst_val", int'(val), 0);
        chk("mid_rst_rolling", int'(rolling), 0);
        chk("mid_rst_done", int'(done), 0);
        step(20);
        chk("mid_rst_no_done", n_dones - d0, 0);
        r0 = n_rolls;
        btn = 1'b1; step(4);
        btn = 1'b0; step(30);
        chk("post_rst_rolls", n_rolls - r0, 1);
        chk("post_rst_len", last_len, Steps * Tick);
        chk("post_rst_dones", n_dones - d0, 1);

        // Random button activity, checked every cycle by the model
        for (int r = 0; r < 8; r++) begin
            for (int s = 0; s < 12; s++) begin
                btn = 1'($urandom_range(0, 1));
                step(int'($urandom_range(1, 12)));
            end
            btn = 1'b0;
            step(40);
        end

        step(2);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
